// File: rtl/cw_il_pkg.sv
// Shared constants and types for the codeword block interleaver.
package cw_il_pkg;

    localparam int unsigned N     = 24;
    localparam int unsigned K     = 16;
    localparam int unsigned B     = 3;
    localparam int unsigned COL_W = $clog2(N);

    typedef logic [0:N-1] cw_t;

    // Row counter width for a bank of the given depth.
    function automatic int unsigned row_w(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/cw_il_bank.sv
// One DEPTH x N interleaver bank: row-wide write port, single-bit (row, col) read port.
// With INTERLEAVER_FLUSH_EN a per-row written mask makes unwritten rows read as zero.
module cw_il_bank
    import cw_il_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ROW_W = row_w(DEPTH)
) (
    input  logic             clk,
`ifdef INTERLEAVER_FLUSH_EN
    input  logic             rst_n,
`endif
    input  logic             i_wr_en,
    input  logic [ROW_W-1:0] i_wr_row,
    input  logic [0:N-1]     i_wr_cw,
    input  logic [ROW_W-1:0] i_rd_row,
    input  logic [COL_W-1:0] i_rd_col,
    output logic             o_rd_bit_c
);

    logic [0:N-1] r_mem [DEPTH];

    // Codeword storage; deliberately not reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_row] <= i_wr_cw;
        end
    end

`ifdef INTERLEAVER_FLUSH_EN
    logic [DEPTH-1:0] r_mask;

    // Written-row mask; a row-0 write starts a new fill and forgets older rows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask <= '0;
        end else if (i_wr_en) begin
            if (i_wr_row == '0) begin
                r_mask <= DEPTH'(1);
            end else begin
                r_mask[i_wr_row] <= 1'b1;
            end
        end
    end

    assign o_rd_bit_c = r_mask[i_rd_row] & r_mem[i_rd_row][i_rd_col];
`else
    assign o_rd_bit_c = r_mem[i_rd_row][i_rd_col];
`endif

endmodule

// File: rtl/cw_interleaver.sv
// Ping-pong block interleaver: codewords fill a bank row by row, full banks drain
// one bit per transfer column-major. Optional INTERLEAVER_FLUSH_EN adds a flush
// input that closes a partially filled bank (missing rows read as zero).
module cw_interleaver
    import cw_il_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [0:N-1] in_cw,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         out_bit,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_sof
`ifdef INTERLEAVER_FLUSH_EN
    ,
    input  logic         flush
`endif
);

    localparam int unsigned ROW_W = row_w(DEPTH);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(DEPTH - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(N - 1);

    if ((DEPTH < 2) || (DEPTH > 16) || (K >= N) || (B == 0)) begin : g_param_check
        $error("cw_interleaver: unsupported configuration");
    end

    logic [1:0]       r_full;
    logic             r_wr_bank;
    logic [ROW_W-1:0] r_wr_row;
    logic             r_rd_bank;
    logic [ROW_W-1:0] r_rd_row;
    logic [COL_W-1:0] r_rd_col;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_out_bit;
    logic             r_out_sof;

    logic [1:0]       w_full_nxt;
    logic             w_wr_bank_nxt;
    logic [ROW_W-1:0] w_wr_row_nxt;
    logic             w_rd_bank_nxt;
    logic [ROW_W-1:0] w_rd_row_nxt;
    logic [COL_W-1:0] w_rd_col_nxt;
    logic             w_close;
    logic             w_accept;
    logic             w_xfer;
    logic [1:0]       w_bank_bit;
    logic             w_bypass;
    logic             w_valid_nxt;
    logic             w_bit_nxt;

    assign w_accept = in_valid && r_in_ready;
    assign w_xfer   = r_out_valid && out_ready;

    // Next state of write pointer, read pointer and bank full flags.
    always_comb begin
        w_full_nxt    = r_full;
        w_wr_bank_nxt = r_wr_bank;
        w_wr_row_nxt  = r_wr_row;
        w_rd_bank_nxt = r_rd_bank;
        w_rd_row_nxt  = r_rd_row;
        w_rd_col_nxt  = r_rd_col;
        w_close       = w_accept && (r_wr_row == ROW_LAST);
`ifdef INTERLEAVER_FLUSH_EN
        // Flush counts the same-cycle write, so it closes any non-empty bank.
        w_close       = w_close || (flush && (w_accept || (r_wr_row != '0)));
`endif

        if (w_accept) begin
            w_wr_row_nxt = r_wr_row + ROW_W'(1);
        end
        if (w_close) begin
            w_full_nxt[r_wr_bank] = 1'b1;
            w_wr_bank_nxt         = ~r_wr_bank;
            w_wr_row_nxt          = '0;
        end

        // Write side only targets a non-full bank, read side only a full one.
        if (w_xfer) begin
            if (r_rd_row == ROW_LAST) begin
                w_rd_row_nxt = '0;
                if (r_rd_col == COL_LAST) begin
                    w_rd_col_nxt          = '0;
                    w_full_nxt[r_rd_bank] = 1'b0;
                    w_rd_bank_nxt         = ~r_rd_bank;
                end else begin
                    w_rd_col_nxt = r_rd_col + COL_W'(1);
                end
            end else begin
                w_rd_row_nxt = r_rd_row + ROW_W'(1);
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        cw_il_bank #(
            .DEPTH (DEPTH),
            .ROW_W (ROW_W)
        ) u_bank (
            .clk        (clk),
`ifdef INTERLEAVER_FLUSH_EN
            .rst_n      (rst_n),
`endif
            .i_wr_en    (w_accept && (r_wr_bank == 1'(b))),
            .i_wr_row   (r_wr_row),
            .i_wr_cw    (in_cw),
            .i_rd_row   (w_rd_row_nxt),
            .i_rd_col   (w_rd_col_nxt),
            .o_rd_bit_c (w_bank_bit[b])
        );
    end

    // Look up the bit at the next read address; a row landing this cycle is forwarded.
    always_comb begin
        w_bypass    = w_accept && (r_wr_bank == w_rd_bank_nxt) && (r_wr_row == w_rd_row_nxt);
        w_valid_nxt = w_full_nxt[w_rd_bank_nxt];
        w_bit_nxt   = w_bypass ? in_cw[w_rd_col_nxt] : w_bank_bit[w_rd_bank_nxt];
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full      <= '0;
            r_wr_bank   <= 1'b0;
            r_wr_row    <= '0;
            r_rd_bank   <= 1'b0;
            r_rd_row    <= '0;
            r_rd_col    <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_bit   <= 1'b0;
            r_out_sof   <= 1'b0;
        end else begin
            r_full      <= w_full_nxt;
            r_wr_bank   <= w_wr_bank_nxt;
            r_wr_row    <= w_wr_row_nxt;
            r_rd_bank   <= w_rd_bank_nxt;
            r_rd_row    <= w_rd_row_nxt;
            r_rd_col    <= w_rd_col_nxt;
            r_in_ready  <= !w_full_nxt[w_wr_bank_nxt];
            r_out_valid <= w_valid_nxt;
            r_out_bit   <= w_valid_nxt && w_bit_nxt;
            r_out_sof   <= w_valid_nxt && (w_rd_row_nxt == '0) && (w_rd_col_nxt == '0);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_bit   = r_out_bit;
    assign out_sof   = r_out_sof;

endmodule

// File: tb/tb_cw_interleaver.sv
// Self-checking bench for cw_interleaver: randomized traffic against a queue-based
// model of the column-major bank drain. Build with INTERLEAVER_FLUSH_EN to cover flush.
module tb_cw_interleaver;
    import cw_il_pkg::*;

    localparam int unsigned DEPTH     = 4;
    localparam int unsigned BANK_BITS = N * DEPTH;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [0:N-1] in_cw;
    logic         in_valid;
    logic         in_ready;
    logic         out_bit;
    logic         out_valid;
    logic         out_ready;
    logic         out_sof;
`ifdef INTERLEAVER_FLUSH_EN
    logic         flush;
`endif

    cw_interleaver #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_cw     (in_cw),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sof   (out_sof)
`ifdef INTERLEAVER_FLUSH_EN
        ,
        .flush     (flush)
`endif
    );

    always #5 clk = ~clk;

    int unsigned  n_pass  = 0;
    int unsigned  n_total = 0;
    int unsigned  n_xfer  = 0;
    logic [1:0]   exp_q [$];   // expected {sof, bit} in channel order
    logic [0:N-1] part_q [$];  // codewords of the bank being filled
    logic         cap_q [$];   // DUT bits actually transferred
    logic         cap_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // A closed bank is read column by column; rows never written read as zero.
    function automatic void close_bank();
        for (int c = 0; c < N; c++) begin
            for (int r = 0; r < DEPTH; r++) begin
                logic b;
                b = (r < part_q.size()) ? part_q[r][c] : 1'b0;
                exp_q.push_back({(r == 0) && (c == 0), b});
            end
        end
        part_q.delete();
    endfunction

    // One cycle: drive inputs at the falling edge, check outputs, predict the rising edge.
    task automatic step(input logic [0:N-1] cw, input logic v, input int unsigned pct,
                        input logic fl, output logic acc);
        logic        rdy;
        logic        exp_rdy;
        int unsigned nfull;
        rdy       = ($urandom_range(99) < pct);
        in_cw     = cw;
        in_valid  = v;
        out_ready = rdy;
`ifdef INTERLEAVER_FLUSH_EN
        flush     = fl;
`endif
        nfull   = (exp_q.size() + BANK_BITS - 1) / BANK_BITS;
        exp_rdy = (nfull < 2);
        check("in_ready", in_ready, exp_rdy);
        check("out_valid", out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check("out_bit", out_bit, exp_q[0][0]);
            check("out_sof", out_sof, exp_q[0][1]);
        end else begin
            check("idle_out", {out_sof, out_bit}, 2'b00);
        end
        acc = v && exp_rdy;
        if (rdy && (exp_q.size() != 0)) begin
            if (cap_en) cap_q.push_back(out_bit);
            void'(exp_q.pop_front());
            n_xfer++;
        end
        if (acc) begin
            part_q.push_back(cw);
            if (part_q.size() == DEPTH) close_bank();
        end
`ifdef INTERLEAVER_FLUSH_EN
        if (fl && (part_q.size() != 0)) close_bank();
`endif
        @(negedge clk);
    endtask

    task automatic write_cw(input logic [0:N-1] cw, input int unsigned pct);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 400 && !acc; i++) step(cw, 1'b1, pct, 1'b0, acc);
        check("write_accepted", acc, 1'b1);
    endtask

    task automatic drain(input int unsigned pct);
        logic acc;
        for (int i = 0; i < 3000 && (exp_q.size() != 0); i++) step('0, 1'b0, pct, 1'b0, acc);
        check("drain_empty", exp_q.size(), 0);
        repeat (3) step('0, 1'b0, pct, 1'b0, acc);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_sof", out_sof, 1'b0);
        check("rst_out_bit", out_bit, 1'b0);
        exp_q.delete();
        part_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic         acc;
        logic [0:N-1] cws [10];
        int unsigned  k;
        int unsigned  snap;
        int unsigned  start;
        rst_n     = 1'b0;
        in_cw     = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
`ifdef INTERLEAVER_FLUSH_EN
        flush     = 1'b0;
`endif
        @(negedge clk);
        do_reset();
        repeat (4) step('0, 1'b0, 100, 1'b0, acc);

        // Column-major ordering with a single all-ones codeword.
        cap_q.delete();
        cap_en = 1'b1;
        write_cw(24'hFFFFFF, 100);
        repeat (3) write_cw(24'h000000, 100);
        drain(100);
        check("order_len", cap_q.size(), BANK_BITS);
        for (int i = 0; i < cap_q.size(); i++) check("order_pat", cap_q[i], (i % 4) == 0);

        // Same data under random backpressure.
        cap_q.delete();
        write_cw(24'hFFFFFF, 50);
        repeat (3) write_cw(24'h000000, 50);
        drain(50);
        check("bp_len", cap_q.size(), BANK_BITS);
        for (int i = 0; i < cap_q.size(); i++) check("bp_pat", cap_q[i], (i % 4) == 0);
        cap_en = 1'b0;

        // Both banks full: eight accepted, ninth waits for the first bank to drain.
        for (int i = 0; i < 10; i++) cws[i] = N'($urandom);
        k = 0;
        for (int i = 0; i < 30; i++) begin
            step(cws[k], k < 9, 0, 1'b0, acc);
            if (acc) k++;
        end
        check("pp_accepted", k, 8);
        start = n_xfer;
        for (int i = 0; i < 400 && ((k < 9) || (exp_q.size() != 0)); i++) begin
            snap = n_xfer;
            step(cws[k], k < 9, 100, 1'b0, acc);
            if (acc) begin
                check("pp_ninth_after", snap - start, BANK_BITS);
                k++;
            end
        end
        check("pp_done", k, 9);

        // Random traffic and backpressure.
        for (int i = 0; i < 1500; i++) begin
            logic fl;
`ifdef INTERLEAVER_FLUSH_EN
            fl = ($urandom_range(99) < 2);
`else
            fl = 1'b0;
`endif
            step(N'($urandom), $urandom_range(99) < 3, 70, fl, acc);
        end
        drain(100);

        // Burst immunity: any 3*DEPTH-bit channel burst hits each codeword in 3 adjacent bits.
        do_reset();
        cap_q.delete();
        cap_en = 1'b1;
        for (int r = 0; r < DEPTH; r++) begin
            cws[r] = N'($urandom);
            write_cw(cws[r], 100);
        end
        drain(100);
        cap_en = 1'b0;
        check("burst_len", cap_q.size(), BANK_BITS);
        if (cap_q.size() == BANK_BITS) begin
            for (int off = 0; off + B * DEPTH <= BANK_BITS; off++) begin
                for (int r = 0; r < DEPTH; r++) begin
                    logic [0:N-1] err;
                    int           first;
                    int           last;
                    int unsigned  pop;
                    first = -1;
                    last  = -1;
                    for (int c = 0; c < N; c++) begin
                        int idx;
                        idx    = c * DEPTH + r;
                        err[c] = cap_q[idx] ^ ((idx >= off) && (idx < off + B * DEPTH)) ^ cws[r][c];
                        if (err[c]) begin
                            if (first < 0) first = c;
                            last = c;
                        end
                    end
                    pop = $countones(err);
                    check("burst_row", (pop << 8) | 32'(last - first + 1), 32'h0303);
                end
            end
        end

        // Reset in the middle of a drain.
        start = n_xfer;
        for (int r = 0; r < DEPTH; r++) write_cw(N'($urandom), 100);
        for (int i = 0; i < 200 && (n_xfer - start < 40); i++) step('0, 1'b0, 100, 1'b0, acc);
        check("mid_xfers", n_xfer - start, 40);
        do_reset();
        repeat (2) step('0, 1'b0, 100, 1'b0, acc);
        for (int r = 0; r < DEPTH; r++) write_cw(N'($urandom), 60);
        drain(60);

`ifdef INTERLEAVER_FLUSH_EN
        // Flush a half-filled bank; missing rows read as zero.
        cap_q.delete();
        cap_en = 1'b1;
        repeat (2) write_cw(24'hFFFFFF, 100);
        step('0, 1'b0, 100, 1'b1, acc);
        drain(100);
        cap_en = 1'b0;
        check("flush_len", cap_q.size(), BANK_BITS);
        for (int i = 0; i < cap_q.size(); i++) check("flush_pat", cap_q[i], (i % 4) < 2);
        // Flush on an empty write row is ignored; a full bank follows normally.
        step('0, 1'b0, 100, 1'b1, acc);
        for (int r = 0; r < DEPTH; r++) write_cw(N'($urandom), 100);
        drain(100);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
